uart_rx_fifo: RTL and testbench
===============================

Name: uart_rx_fifo

Overview:
- UART receive front end feeding the CPU's memory-mapped UART peripheral. Consumes the raw pad `rx` line and delivers received bytes to the CPU.
- Frame format: 8N1 (8 data bits, no parity, 1 stop bit), LSB first. Each bit is sampled once, at its midpoint.
- Completed bytes are buffered in a small FIFO. The CPU pops them with a valid/ack handshake, so back-to-back frames are absorbed while the CPU is busy.
- Line errors are reported as status flags.

Parameters:
- CLKS_PER_BIT, 2815: clock cycles per bit. Default gives 9600 baud at a 37 ns clock.
- DEPTH_LOG2, 2: log2 of FIFO depth (default depth 4).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- rx  in  1  asynchronous serial line; idles at 1
- rd_data  out  8  FIFO head byte; valid when rd_valid=1
- rd_valid  out  1  FIFO non-empty
- rd_ack  in  1  pop head; ignored when rd_valid=0
- overrun  out  1  sticky: a byte was dropped because the FIFO was full
- frame_err  out  1  sticky: stop bit sampled as 0
- parity_err  out  1  sticky: parity mismatch; constant 0 unless UART_RX_PARITY_EN
- err_clr  in  1  clears all three sticky flags
- busy  out  1  receiver FSM not in IDLE

Behaviour:
- Reset (rst=1 at posedge clk):
  - Synchronizer flops set to 1; FSM enters IDLE; bit counter and cycle counter set to 0.
  - FIFO emptied. All outputs are 0; rd_data=8'h00.
  - Reset mid-frame abandons the frame; no partial byte is written.
- Synchronizer: two flops on rx. All logic uses the second flop (rxs).
- FSM states:
  - IDLE: when rxs=0, go to START and clear the cycle counter.
  - START: at count CLKS_PER_BIT/2-1 (integer divide), sample rxs.
    - rxs=0: go to DATA and clear the counter.
    - rxs=1: glitch; return to IDLE with no flag set.
  - DATA: at count CLKS_PER_BIT-1, shift rxs into bit 7 of the shift register (right shift, so LSB arrives first) and clear the counter. After the 8th bit, go to PARITY if enabled, otherwise STOP.
  - PARITY (option only): sample the bit at count CLKS_PER_BIT-1, then go to STOP.
  - STOP: sample at count CLKS_PER_BIT-1.
    - rxs=1 and parity OK: push the byte; go to IDLE.
    - rxs=0: set frame_err; discard the byte; go to BREAK.
    - Parity mismatch (stop bit good): set parity_err; discard the byte; go to IDLE.
  - BREAK: wait for rxs=1, then go to IDLE. Prevents a held-low line from re-triggering frames.
- Latency: push happens CLKS_PER_BIT/2 + 9*CLKS_PER_BIT cycles after the first rxs=0 cycle. rd_valid rises the cycle after the push.
- FIFO:
  - Depth 2^DEPTH_LOG2. Pointers are DEPTH_LOG2+1 bits, wrapping naturally.
  - rd_data shows the head combinationally from the registered array.
- Push while full: byte dropped, overrun set, FIFO unchanged.
- Push and rd_ack in the same cycle:
  - Both take effect; occupancy is unchanged.
  - When full, the push succeeds (the pop frees the slot) and overrun is not set.
- rd_ack while empty: no effect, no flag.
- err_clr and a new error in the same cycle: the flag ends at 1 (set wins).
- busy=0 only in IDLE.

Optional Feature:
- Macro: UART_RX_PARITY_EN.
- Defined:
  - Frame is 8E1: an even-parity bit follows the data bits.
  - PARITY state is present. Error if (^data ^ parity bit) != 0.
  - parity_err is live.
- Undefined:
  - 8N1; no PARITY state.
  - parity_err tied to 0.

Test Plan:
- 0x55 at CLKS_PER_BIT=16: frame sent, rd_ack held 0 → rd_valid=1 exactly 16/2+9*16+1 cycles after the rx falling edge reaches rxs; rd_data=8'h55. Then one cycle of rd_ack → rd_valid=0.
- Bytes 0x01,0x80,0xFF,0x3C,0xA5 back-to-back, no ack: first four read out in order on successive acks; 0xA5 dropped; overrun=1. Then err_clr → overrun=0.
- 0.25-bit low glitch on rx while idle: no push, busy returns to 0, no flag set.
- 0x0A sent with stop bit forced 0 and rx then held low 3 bit times: frame_err=1, FIFO stays empty. Next frame 0x69 after rx returns high is received correctly.
- FIFO full and new frame completes in the same cycle as rd_ack: overrun stays 0; after draining, the last byte read is the new one.
- With UART_RX_PARITY_EN: 0x07 sent with parity bit 1 → accepted; 0x07 sent with parity bit 0 → parity_err=1, nothing pushed. rst asserted mid-DATA → FIFO empty, busy=0 the next cycle.

Source files
------------

// File: rtl/uart_rx_fifo_if.sv
// uart_rx_fifo_if: read-side handshake between the UART receive FIFO and the CPU.
//
// Handshake: rd_valid=1 means rd_data holds the FIFO head byte. The consumer
// pops that byte by asserting rd_ack for one clock while rd_valid=1. rd_ack
// while rd_valid=0 is ignored. rd_data/rd_valid never depend on rd_ack in
// the same cycle.
//
// Signals:
//   rd_data  [7:0]  FIFO head byte (producer -> consumer)
//   rd_valid        FIFO non-empty (producer -> consumer)
//   rd_ack          pop request (consumer -> producer)
//
// Modports:
//   slave   FIFO side, which supplies the bytes
//   master  CPU side, which pops the bytes
interface uart_rx_fifo_if;
    logic [7:0] rd_data;
    logic       rd_valid;
    logic       rd_ack;

    modport slave  (output rd_data, output rd_valid, input  rd_ack);
    modport master (input  rd_data, input  rd_valid, output rd_ack);
endinterface

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: UART receiver (8N1, or 8E1 with UART_RX_PARITY_EN) feeding
// a small byte FIFO that the CPU drains through a valid/ack handshake.
//
// Optional feature macro: UART_RX_PARITY_EN
//   undefined: 8N1 frames; parity_err is constant 0.
//   defined:   8E1 frames; a PARITY state samples the even-parity bit and
//              a mismatch sets parity_err and discards the byte.
//
// Ports:
//   clk         system clock
//   rst         synchronous reset, active-high
//   rx          asynchronous serial line, idles high
//   rd          read handshake (rd_data, rd_valid, rd_ack), slave side
//   overrun     sticky: byte dropped because the FIFO was full
//   frame_err   sticky: stop bit sampled as 0
//   parity_err  sticky: parity mismatch
//   err_clr     clears all three sticky flags (a same-cycle set wins)
//   busy        receiver FSM not in IDLE
//   fsm_state   receiver FSM state, for observation
module uart_rx_fifo #(
    parameter int CLKS_PER_BIT = 2815,
    parameter int DEPTH_LOG2   = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         rx,
    uart_rx_fifo_if.slave rd,
    output logic         overrun,
    output logic         frame_err,
    output logic         parity_err,
    input  logic         err_clr,
    output logic         busy,
    output logic [2:0]   fsm_state
);

    localparam int CW    = $clog2(CLKS_PER_BIT);
    localparam int DEPTH = 1 << DEPTH_LOG2;

    localparam logic [CW-1:0] HALF_CNT = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(CLKS_PER_BIT - 1);

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] START  = 3'd1;
    localparam logic [2:0] DATA   = 3'd2;
`ifdef UART_RX_PARITY_EN
    localparam logic [2:0] PARITY = 3'd3;
`endif
    localparam logic [2:0] STOP   = 3'd4;
    localparam logic [2:0] BREAK  = 3'd5;

    logic          rx_meta;
    logic          rxs;
    logic [2:0]    state;
    logic [CW-1:0] cnt;
    logic [2:0]    bit_cnt;
    logic [7:0]    shreg;
    logic          at_full;
    logic          parity_ok;
    logic          push_req;
    logic          set_frame;
    logic          set_parity;

`ifdef UART_RX_PARITY_EN
    logic          par_bit;
    // Even parity: data bits plus parity bit must XOR to 0.
    assign parity_ok = ~(^shreg ^ par_bit);
`else
    assign parity_ok = 1'b1;
`endif

    assign at_full   = (cnt == FULL_CNT);
    assign busy      = (state != IDLE);
    assign fsm_state = state;

    // Stop-bit outcome: framing is checked before parity, so a bad stop bit
    // always reports frame_err even if the parity also mismatched.
    always_comb begin
        push_req   = 1'b0;
        set_frame  = 1'b0;
        set_parity = 1'b0;
        if (state == STOP && at_full) begin
            if (!rxs)            set_frame  = 1'b1;
            else if (!parity_ok) set_parity = 1'b1;
            else                 push_req   = 1'b1;
        end
    end

    // Receiver: two-flop synchronizer and frame FSM.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta <= 1'b1;
            rxs     <= 1'b1;
            state   <= IDLE;
            cnt     <= '0;
            bit_cnt <= '0;
            shreg   <= '0;
`ifdef UART_RX_PARITY_EN
            par_bit <= 1'b0;
`endif
        end else begin
            rx_meta <= rx;
            rxs     <= rx_meta;
            case (state)
                IDLE: begin
                    cnt <= '0;
                    if (!rxs) state <= START;
                end
                START: begin
                    if (cnt == HALF_CNT) begin
                        cnt     <= '0;
                        bit_cnt <= '0;
                        // A start bit that is high again at mid-bit was a glitch.
                        state   <= rxs ? IDLE : DATA;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                DATA: begin
                    if (at_full) begin
                        cnt     <= '0;
                        shreg   <= {rxs, shreg[7:1]};
                        bit_cnt <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                            state <= PARITY;
`else
                            state <= STOP;
`endif
                        end
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
`ifdef UART_RX_PARITY_EN
                PARITY: begin
                    if (at_full) begin
                        cnt     <= '0;
                        par_bit <= rxs;
                        state   <= STOP;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
`endif
                STOP: begin
                    if (at_full) begin
                        cnt   <= '0;
                        // A low stop bit may be a break; wait for the line to recover.
                        state <= rxs ? IDLE : BREAK;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                BREAK: begin
                    if (rxs) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // FIFO with one extra pointer bit to tell full from empty.
    logic [7:0]          mem [DEPTH];
    logic [DEPTH_LOG2:0] wp;
    logic [DEPTH_LOG2:0] rp;
    logic                empty;
    logic                full;
    logic                pop;
    logic                push_ok;
    logic                drop;

    assign empty   = (wp == rp);
    assign full    = (wp[DEPTH_LOG2] != rp[DEPTH_LOG2]) &&
                     (wp[DEPTH_LOG2-1:0] == rp[DEPTH_LOG2-1:0]);
    assign pop     = rd.rd_ack && !empty;
    // A pop in the same cycle frees the slot, so a push into a full FIFO succeeds.
    assign push_ok = push_req && (!full || pop);
    assign drop    = push_req && full && !pop;

    assign rd.rd_valid = !empty;
    assign rd.rd_data  = mem[rp[DEPTH_LOG2-1:0]];

    always_ff @(posedge clk) begin
        if (rst) begin
            wp         <= '0;
            rp         <= '0;
            overrun    <= 1'b0;
            frame_err  <= 1'b0;
            parity_err <= 1'b0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= 8'h00;
        end else begin
            if (push_ok) begin
                mem[wp[DEPTH_LOG2-1:0]] <= shreg;
                wp <= wp + 1'b1;
            end
            if (pop) rp <= rp + 1'b1;
            overrun    <= (overrun    && !err_clr) || drop;
            frame_err  <= (frame_err  && !err_clr) || set_frame;
            parity_err <= (parity_err && !err_clr) || set_parity;
        end
    end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb_uart_rx_fifo: directed bench for uart_rx_fifo at CLKS_PER_BIT=16,
// FIFO depth 4. Frames are driven bit by bit on rx; outputs are sampled
// on the falling clock edge or 1 ns after the rising edge.
module tb_uart_rx_fifo;

    localparam int CPB = 16;
`ifdef UART_RX_PARITY_EN
    localparam int NBITS = 10;
`else
    localparam int NBITS = 9;
`endif
    // Rising edges from driving the start bit low to the push edge:
    // two synchronizer edges, then CPB/2 + NBITS*CPB.
    localparam int PUSH_EDGE = 2 + CPB / 2 + NBITS * CPB + 1;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx  = 1'b1;
    logic       err_clr = 1'b0;
    logic       overrun, frame_err, parity_err, busy;
    logic [2:0] fsm_state;

    int n_checks = 0;
    int n_pass   = 0;

    uart_rx_fifo_if rd_if ();

    uart_rx_fifo #(.CLKS_PER_BIT(CPB), .DEPTH_LOG2(2)) dut (
        .clk        (clk),
        .rst        (rst),
        .rx         (rx),
        .rd         (rd_if.slave),
        .overrun    (overrun),
        .frame_err  (frame_err),
        .parity_err (parity_err),
        .err_clr    (err_clr),
        .busy       (busy),
        .fsm_state  (fsm_state)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic hold_bit(input logic v);
        rx = v;
        repeat (CPB) @(negedge clk);
    endtask

    // Drives one full frame starting at the current negedge.
    task automatic send_frame(input logic [7:0] b, input logic par, input logic stop);
        hold_bit(1'b0);
        for (int i = 0; i < 8; i++) hold_bit(b[i]);
`ifdef UART_RX_PARITY_EN
        hold_bit(par);
`else
        if (par === 1'bx) rx = 1'b1;
`endif
        hold_bit(stop);
        rx = 1'b1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        send_frame(b, ^b, 1'b1);
    endtask

    task automatic pop_check(input string tag, input logic [7:0] exp);
        check({tag, "_valid"}, rd_if.rd_valid, 1'b1);
        check({tag, "_data"}, rd_if.rd_data, exp);
        rd_if.rd_ack = 1'b1;
        @(negedge clk);
        rd_if.rd_ack = 1'b0;
    endtask

    logic [7:0] burst [5];

    initial begin
        rd_if.rd_ack = 1'b0;
        burst[0] = 8'h01; burst[1] = 8'h80; burst[2] = 8'hFF;
        burst[3] = 8'h3C; burst[4] = 8'hA5;

        // Reset state
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst_valid", rd_if.rd_valid, 1'b0);
        check("rst_data", rd_if.rd_data, 8'h00);
        check("rst_overrun", overrun, 1'b0);
        check("rst_frame_err", frame_err, 1'b0);
        check("rst_parity_err", parity_err, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_state", fsm_state, 3'd0);

        // 0x55: rd_valid rises exactly on the edge after the push
        fork
            send_byte(8'h55);
            begin
                repeat (PUSH_EDGE - 1) @(posedge clk);
                #1 check("lat_before", rd_if.rd_valid, 1'b0);
                @(posedge clk);
                #1 check("lat_at", rd_if.rd_valid, 1'b1);
            end
        join
        check("x55_data", rd_if.rd_data, 8'h55);
        check("x55_busy", busy, 1'b0);
        rd_if.rd_ack = 1'b1;
        @(negedge clk);
        rd_if.rd_ack = 1'b0;
        check("x55_popped", rd_if.rd_valid, 1'b0);

        // ack while empty has no effect
        rd_if.rd_ack = 1'b1;
        @(negedge clk);
        rd_if.rd_ack = 1'b0;
        check("empty_ack_valid", rd_if.rd_valid, 1'b0);
        check("empty_ack_overrun", overrun, 1'b0);

        // Five back-to-back frames into a depth-4 FIFO
        for (int i = 0; i < 5; i++) send_byte(burst[i]);
        repeat (2) @(negedge clk);
        check("burst_overrun", overrun, 1'b1);
        for (int i = 0; i < 4; i++) pop_check("burst", burst[i]);
        check("burst_drained", rd_if.rd_valid, 1'b0);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        check("overrun_cleared", overrun, 1'b0);

        // Quarter-bit glitch while idle
        rx = 1'b0;
        repeat (CPB / 4) @(negedge clk);
        rx = 1'b1;
        check("glitch_busy", busy, 1'b1);
        repeat (2 * CPB) @(negedge clk);
        check("glitch_idle", busy, 1'b0);
        check("glitch_valid", rd_if.rd_valid, 1'b0);
        check("glitch_frame_err", frame_err, 1'b0);

        // Bad stop bit, then line held low for 3 bit times
        send_frame(8'h0A, ^8'h0A, 1'b0);
        rx = 1'b0;
        repeat (3 * CPB) @(negedge clk);
        check("break_frame_err", frame_err, 1'b1);
        check("break_busy", busy, 1'b1);
        check("break_valid", rd_if.rd_valid, 1'b0);
        rx = 1'b1;
        repeat (4) @(negedge clk);
        check("break_released", busy, 1'b0);
        send_byte(8'h69);
        @(negedge clk);
        pop_check("after_break", 8'h69);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        check("frame_err_cleared", frame_err, 1'b0);

        // Full FIFO: push and ack land on the same edge
        send_byte(8'h11);
        send_byte(8'h22);
        send_byte(8'h33);
        send_byte(8'h44);
        fork
            send_byte(8'h5A);
            begin
                repeat (PUSH_EDGE - 1) @(negedge clk);
                rd_if.rd_ack = 1'b1;
                @(negedge clk);
                rd_if.rd_ack = 1'b0;
            end
        join
        check("full_ack_overrun", overrun, 1'b0);
        pop_check("full_ack", 8'h22);
        pop_check("full_ack", 8'h33);
        pop_check("full_ack", 8'h44);
        pop_check("full_ack_new", 8'h5A);
        check("full_ack_drained", rd_if.rd_valid, 1'b0);
        check("full_ack_overrun_end", overrun, 1'b0);

`ifdef UART_RX_PARITY_EN
        // 0x07 has three ones: even parity bit is 1
        send_frame(8'h07, 1'b1, 1'b1);
        @(negedge clk);
        check("par_ok_err", parity_err, 1'b0);
        pop_check("par_ok", 8'h07);
        send_frame(8'h07, 1'b0, 1'b1);
        @(negedge clk);
        check("par_bad_err", parity_err, 1'b1);
        check("par_bad_valid", rd_if.rd_valid, 1'b0);
`endif

        // Reset in the middle of the data bits
        hold_bit(1'b0);
        hold_bit(1'b1);
        hold_bit(1'b0);
        rx = 1'b1;
        check("mid_busy", busy, 1'b1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("mid_rst_busy", busy, 1'b0);
        check("mid_rst_valid", rd_if.rd_valid, 1'b0);
        repeat (NBITS * CPB) @(negedge clk);
        check("mid_rst_no_push", rd_if.rd_valid, 1'b0);
        check("mid_rst_idle", busy, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
